// File: rtl/pf_ddr4_lane_rd_train_ctrl_pkg.sv
// Shared types and defaults for the per-lane DDR4 read-training controller.
package pf_ddr4_rd_train_pkg;

  localparam int TAP_W_DEF      = 8;
  localparam int MAX_TAP_DEF    = 127;
  localparam int SETTLE_CYC_DEF = 4;
  localparam int SAMPLE_CYC_DEF = 64;
  localparam int RETRY_MAX_DEF  = 2;
  localparam int CNT_W          = 16;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD    = 4'd1,
    S_SETTLE  = 4'd2,
    S_CLEAR   = 4'd3,
    S_SAMPLE  = 4'd4,
    S_EVAL    = 4'd5,
    S_STEP    = 4'd6,
    S_RESOLVE = 4'd7,
    S_CLOAD   = 4'd8,
    S_CSETTLE = 4'd9,
    S_CMOVE   = 4'd10,
    S_DONE    = 4'd11,
    S_FAIL    = 4'd12
  } train_state_e;

endpackage

// File: rtl/pf_ddr4_lane_rd_train_ctrl_if.sv
// Lane-level signal bundle: PHY training handshake plus lane IOD delay/eye-monitor controls.
interface pf_ddr4_lane_rd_train_ctrl_if
  import pf_ddr4_rd_train_pkg::*;
#(
  parameter int TAP_W = TAP_W_DEF
);

  logic             START;
  logic             BUSY;
  logic             DONE;
  logic             ERR;
  logic [TAP_W-1:0] CENTER_TAP;
  logic [TAP_W:0]   WIN_LEN;
  logic             EYE_MONITOR_EARLY;
  logic             EYE_MONITOR_LATE;
  logic             DELAY_LINE_OUT_OF_RANGE;
  logic             DELAY_LINE_LOAD;
  logic             DELAY_LINE_MOVE;
  logic             DELAY_LINE_DIRECTION;
  logic             EYE_MONITOR_CLEAR_FLAGS;

  modport master (
    input  START, EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE,
    output BUSY, DONE, ERR, CENTER_TAP, WIN_LEN,
           DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS
  );

  modport slave (
    output START, EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE,
    input  BUSY, DONE, ERR, CENTER_TAP, WIN_LEN,
           DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS
  );

endinterface

// File: rtl/pf_ddr4_lane_rd_train_ctrl_win_track.sv
// Passing-window tracker: keeps the current run of passing taps and the best (longest, earliest) run.
module pf_ddr4_rd_train_win_track
  import pf_ddr4_rd_train_pkg::*;
#(
  parameter int TAP_W = TAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             eval,
  input  logic             pass,
  input  logic [TAP_W-1:0] tap,
  output logic [TAP_W-1:0] best_start,
  output logic [TAP_W:0]   best_len
);

  logic [TAP_W-1:0] cur_start_r;
  logic [TAP_W:0]   cur_len_r;
  logic [TAP_W-1:0] best_start_r;
  logic [TAP_W:0]   best_len_r;
  logic [TAP_W-1:0] run_start_s;
  logic [TAP_W:0]   run_len_s;

  // A run that starts on this tap takes the tap as its origin
  always_comb begin
    run_len_s = cur_len_r + {{TAP_W{1'b0}}, 1'b1};
    if (cur_len_r == {(TAP_W+1){1'b0}}) begin
      run_start_s = tap;
    end else begin
      run_start_s = cur_start_r;
    end
  end

  // Strict '>' keeps the earliest of equal-length windows
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cur_start_r  <= {TAP_W{1'b0}};
      cur_len_r    <= {(TAP_W+1){1'b0}};
      best_start_r <= {TAP_W{1'b0}};
      best_len_r   <= {(TAP_W+1){1'b0}};
    end else if (eval) begin
      if (pass) begin
        cur_start_r <= run_start_s;
        cur_len_r   <= run_len_s;
        if (run_len_s > best_len_r) begin
          best_start_r <= run_start_s;
          best_len_r   <= run_len_s;
        end
      end else begin
        cur_len_r <= {(TAP_W+1){1'b0}};
      end
    end
  end

  assign best_start = best_start_r;
  assign best_len   = best_len_r;

endmodule

// File: rtl/pf_ddr4_lane_rd_train_ctrl.sv
// Per-lane DDR4 read-training sequencer: sweeps the RX delay line, scores taps, centres on the best window.
// Optional feature macro: LANE_RD_TRAIN_RETRY_EN (re-sweep on failure up to RETRY_MAX times).
module pf_ddr4_lane_rd_train_ctrl
  import pf_ddr4_rd_train_pkg::*;
#(
  parameter int TAP_W      = TAP_W_DEF,
  parameter int MAX_TAP    = MAX_TAP_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int SAMPLE_CYC = SAMPLE_CYC_DEF,
  parameter int RETRY_MAX  = RETRY_MAX_DEF
) (
  input logic                          FAB_CLK,
  input logic                          RX_SYNC_RST,
  pf_ddr4_lane_rd_train_ctrl_if.master lane
);

`ifdef LANE_RD_TRAIN_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam logic [TAP_W-1:0] MAX_TAP_T   = TAP_W'(MAX_TAP);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);
  localparam logic [7:0]       RETRY_LIM   = 8'(RETRY_MAX);

  train_state_e     state_r, state_nxt;
  logic [CNT_W-1:0] wait_r;
  logic [TAP_W-1:0] tap_r;
  logic [TAP_W-1:0] center_r;
  logic [TAP_W:0]   win_len_r;
  logic [7:0]       retry_cnt_r;
  logic             acc_r;
  logic             load_r, move_r, dir_r, clear_r, busy_r, done_r, err_r;

  logic             start_ok_s;
  logic             retry_ok_s;
  logic             eval_s;
  logic             track_clear_s;
  logic [TAP_W-1:0] best_start_s;
  logic [TAP_W:0]   best_len_s;
  logic [TAP_W-1:0] center_s;

  assign eval_s        = (state_r == S_EVAL);
  assign track_clear_s = (state_r == S_LOAD);
  assign retry_ok_s    = RETRY_EN && (retry_cnt_r < RETRY_LIM);
  assign center_s      = TAP_W'({1'b0, best_start_s} + (best_len_s >> 1));

  pf_ddr4_rd_train_win_track #(.TAP_W(TAP_W)) u_win_track (
    .clk        (FAB_CLK),
    .rst        (RX_SYNC_RST),
    .clear      (track_clear_s),
    .eval       (eval_s),
    .pass       (~acc_r),
    .tap        (tap_r),
    .best_start (best_start_s),
    .best_len   (best_len_s)
  );

  // Next-state logic; START is also honoured in the DONE/FAIL cycle since BUSY is already low there
  always_comb begin
    state_nxt  = state_r;
    start_ok_s = 1'b0;
    case (state_r)
      S_IDLE, S_DONE, S_FAIL: begin
        if (lane.START) begin
          start_ok_s = 1'b1;
          state_nxt  = S_LOAD;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_LOAD:   state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (wait_r == SETTLE_LAST) state_nxt = S_CLEAR;
        else                       state_nxt = S_SETTLE;
      end
      S_CLEAR:  state_nxt = S_SAMPLE;
      S_SAMPLE: begin
        if (wait_r == SAMPLE_LAST) state_nxt = S_EVAL;
        else                       state_nxt = S_SAMPLE;
      end
      S_EVAL: begin
        if ((tap_r == MAX_TAP_T) || lane.DELAY_LINE_OUT_OF_RANGE) state_nxt = S_RESOLVE;
        else                                                      state_nxt = S_STEP;
      end
      S_STEP:   state_nxt = S_SETTLE;
      S_RESOLVE: begin
        if (best_len_s != {(TAP_W+1){1'b0}}) state_nxt = S_CLOAD;
        else if (retry_ok_s)                 state_nxt = S_LOAD;
        else                                 state_nxt = S_FAIL;
      end
      S_CLOAD:  state_nxt = S_CSETTLE;
      S_CSETTLE: begin
        if (wait_r != SETTLE_LAST)  state_nxt = S_CSETTLE;
        else if (tap_r < center_r)  state_nxt = S_CMOVE;
        else                        state_nxt = S_DONE;
      end
      S_CMOVE:  state_nxt = S_CSETTLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State, wait/tap counters, flag accumulator and training results
  always_ff @(posedge FAB_CLK) begin
    if (RX_SYNC_RST) begin
      state_r     <= S_IDLE;
      wait_r      <= {CNT_W{1'b0}};
      tap_r       <= {TAP_W{1'b0}};
      center_r    <= {TAP_W{1'b0}};
      win_len_r   <= {(TAP_W+1){1'b0}};
      retry_cnt_r <= 8'd0;
      acc_r       <= 1'b0;
    end else begin
      state_r <= state_nxt;
      if (state_nxt == state_r) wait_r <= wait_r + CNT_W'(1);
      else                      wait_r <= {CNT_W{1'b0}};
      // The tap counter doubles as the centre-move counter after CLOAD
      if ((state_r == S_LOAD) || (state_r == S_CLOAD))      tap_r <= {TAP_W{1'b0}};
      else if ((state_r == S_STEP) || (state_r == S_CMOVE)) tap_r <= tap_r + TAP_W'(1);
      if (state_r == S_CLEAR)       acc_r <= 1'b0;
      else if (state_r == S_SAMPLE) acc_r <= acc_r | lane.EYE_MONITOR_EARLY | lane.EYE_MONITOR_LATE;
      if (start_ok_s) begin
        retry_cnt_r <= 8'd0;
        center_r    <= {TAP_W{1'b0}};
        win_len_r   <= {(TAP_W+1){1'b0}};
      end else if (state_r == S_RESOLVE) begin
        win_len_r <= best_len_s;
        if (best_len_s != {(TAP_W+1){1'b0}}) center_r <= center_s;
        else if (retry_ok_s)                 retry_cnt_r <= retry_cnt_r + 8'd1;
      end
    end
  end

  // Strobes are registered from the next state so each pulse covers exactly its state's cycle
  always_ff @(posedge FAB_CLK) begin
    if (RX_SYNC_RST) begin
      load_r  <= 1'b0;
      move_r  <= 1'b0;
      dir_r   <= 1'b0;
      clear_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      load_r  <= (state_nxt == S_LOAD) || (state_nxt == S_CLOAD);
      move_r  <= (state_nxt == S_STEP) || (state_nxt == S_CMOVE);
      dir_r   <= (state_nxt == S_STEP) || (state_nxt == S_CMOVE);
      clear_r <= (state_nxt == S_CLEAR);
      busy_r  <= (state_nxt != S_IDLE) && (state_nxt != S_DONE) && (state_nxt != S_FAIL);
      done_r  <= (state_nxt == S_DONE);
      err_r   <= (state_nxt == S_FAIL);
    end
  end

  assign lane.DELAY_LINE_LOAD         = load_r;
  assign lane.DELAY_LINE_MOVE         = move_r;
  assign lane.DELAY_LINE_DIRECTION    = dir_r;
  assign lane.EYE_MONITOR_CLEAR_FLAGS = clear_r;
  assign lane.BUSY                    = busy_r;
  assign lane.DONE                    = done_r;
  assign lane.ERR                     = err_r;
  assign lane.CENTER_TAP              = center_r;
  assign lane.WIN_LEN                 = win_len_r;

endmodule

// File: tb/tb_pf_ddr4_lane_rd_train_ctrl.sv
// Directed bench for pf_ddr4_lane_rd_train_ctrl with a small behavioural lane-IOD model.
module tb_pf_ddr4_lane_rd_train_ctrl;

  logic FAB_CLK;
  logic RX_SYNC_RST;

  pf_ddr4_lane_rd_train_ctrl_if #(.TAP_W(8)) lane ();

  pf_ddr4_lane_rd_train_ctrl #(
    .TAP_W(8), .MAX_TAP(15), .SETTLE_CYC(2), .SAMPLE_CYC(8), .RETRY_MAX(2)
  ) dut (
    .FAB_CLK     (FAB_CLK),
    .RX_SYNC_RST (RX_SYNC_RST),
    .lane        (lane)
  );

  initial begin
    FAB_CLK = 1'b0;
    forever #5 FAB_CLK = ~FAB_CLK;
  end

  int total = 0;
  int bad   = 0;

  // IOD model and per-run observations
  logic [15:0] fail_mask;
  bit          late_mode;
  int          oor_tap;
  int          model_tap;
  int          late_cd;
  int          load_cnt, move_cnt, done_cnt, err_cnt, viol, cyc;
  int          busy1, res_center, res_win;
  bit          clear_seen;

  task automatic check_val(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, act, exp);
    end
  endtask

  // One clock: observe DUT strobes at the falling edge and update the IOD model
  task automatic tick();
    @(negedge FAB_CLK);
    cyc++;
    lane.START = 1'b0;
    if ((32'(lane.DELAY_LINE_LOAD) + 32'(lane.DELAY_LINE_MOVE) + 32'(lane.EYE_MONITOR_CLEAR_FLAGS)) > 1) viol++;
    if (lane.DELAY_LINE_MOVE && !lane.DELAY_LINE_DIRECTION) viol++;
    if (lane.DELAY_LINE_MOVE && lane.DELAY_LINE_OUT_OF_RANGE) viol++;
    if (lane.DELAY_LINE_LOAD) begin
      model_tap = 0;
      load_cnt++;
      move_cnt = 0;
    end
    if (lane.DELAY_LINE_MOVE) begin
      model_tap++;
      move_cnt++;
    end
    lane.EYE_MONITOR_LATE = 1'b0;
    if (late_cd != 0) begin
      late_cd--;
      if (late_cd == 0) lane.EYE_MONITOR_LATE = 1'b1;
    end
    clear_seen = lane.EYE_MONITOR_CLEAR_FLAGS;
    if (lane.EYE_MONITOR_CLEAR_FLAGS) begin
      lane.EYE_MONITOR_EARLY = (model_tap < 16) ? fail_mask[model_tap] : 1'b1;
      late_cd = late_mode ? 3 : 0;
    end
    lane.DELAY_LINE_OUT_OF_RANGE = (model_tap >= oor_tap);
    if (lane.DONE) done_cnt++;
    if (lane.ERR)  err_cnt++;
  endtask

  task automatic setup_run(input logic [15:0] mask, input bit late_en, input int oor_t);
    fail_mask = mask;
    late_mode = late_en;
    oor_tap   = oor_t;
    late_cd   = 0;
    lane.EYE_MONITOR_EARLY = 1'b0;
    lane.EYE_MONITOR_LATE  = 1'b0;
    lane.DELAY_LINE_OUT_OF_RANGE = (model_tap >= oor_tap);
    load_cnt = 0; move_cnt = 0; done_cnt = 0; err_cnt = 0; viol = 0; cyc = 0;
  endtask

  task automatic run_train(input logic [15:0] mask, input bit late_en, input int oor_t);
    setup_run(mask, late_en, oor_t);
    lane.START = 1'b1;
    tick();
    busy1 = 32'(lane.BUSY);
    while (done_cnt == 0 && err_cnt == 0 && cyc < 5000) tick();
    if (cyc >= 5000) check_val("timeout", cyc, 0);
    res_center = 32'(lane.CENTER_TAP);
    res_win    = 32'(lane.WIN_LEN);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_busy"},  32'(lane.BUSY), 0);
    check_val({tag, "_load"},  32'(lane.DELAY_LINE_LOAD), 0);
    check_val({tag, "_move"},  32'(lane.DELAY_LINE_MOVE), 0);
    check_val({tag, "_clear"}, 32'(lane.EYE_MONITOR_CLEAR_FLAGS), 0);
    check_val({tag, "_done"},  32'(lane.DONE), 0);
    check_val({tag, "_err"},   32'(lane.ERR), 0);
  endtask

  initial begin
    int exp_loads;
    int exp_err_cyc;
    RX_SYNC_RST = 1'b1;
    lane.START = 1'b0;
    lane.EYE_MONITOR_EARLY = 1'b0;
    lane.EYE_MONITOR_LATE = 1'b0;
    lane.DELAY_LINE_OUT_OF_RANGE = 1'b0;
    model_tap = 0; late_cd = 0; late_mode = 1'b0; oor_tap = 255; fail_mask = 16'h0000;
    repeat (3) @(negedge FAB_CLK);
    check_idle_outputs("reset");
    check_val("reset_center", 32'(lane.CENTER_TAP), 0);
    check_val("reset_winlen", 32'(lane.WIN_LEN), 0);
    RX_SYNC_RST = 1'b0;
    tick();
    check_val("reset_no_load", load_cnt, 0);

    // 1: every tap passes -> window 0..15, centre 0+16/2
    run_train(16'h0000, 1'b0, 255);
    check_val("t1_busy_after_start", busy1, 1);
    check_val("t1_done", done_cnt, 1);
    check_val("t1_err", err_cnt, 0);
    check_val("t1_busy_at_done", 32'(lane.BUSY), 0);
    check_val("t1_center", res_center, 8);
    check_val("t1_winlen", res_win, 16);
    check_val("t1_loads", load_cnt, 2);
    check_val("t1_centre_moves", move_cnt, 8);
    check_val("t1_latency", cyc, 237);
    check_val("t1_rules", viol, 0);
    repeat (3) tick();
    check_val("t1_center_held", 32'(lane.CENTER_TAP), 8);
    check_val("t1_done_single", done_cnt, 1);

    // 2: pass 4..9 -> len 6, centre 4+3
    run_train(16'hFC0F, 1'b0, 255);
    check_val("t2_done", done_cnt, 1);
    check_val("t2_center", res_center, 7);
    check_val("t2_winlen", res_win, 6);
    check_val("t2_centre_moves", move_cnt, 7);
    check_val("t2_latency", cyc, 234);
    check_val("t2_rules", viol, 0);

    // 3: pass 2..4 and 10..12 -> earlier window kept, centre 2+1
    run_train(16'hE3E3, 1'b0, 255);
    check_val("t3_center", res_center, 3);
    check_val("t3_winlen", res_win, 3);
    check_val("t3_centre_moves", move_cnt, 3);
    check_val("t3_rules", viol, 0);

    // 4: one LATE pulse mid-sample on every tap -> all fail
`ifdef LANE_RD_TRAIN_RETRY_EN
    exp_loads = 3;
    exp_err_cyc = 628;
`else
    exp_loads = 1;
    exp_err_cyc = 210;
`endif
    run_train(16'h0000, 1'b1, 255);
    check_val("t4_err", err_cnt, 1);
    check_val("t4_done", done_cnt, 0);
    check_val("t4_winlen", res_win, 0);
    check_val("t4_sweep_loads", load_cnt, exp_loads);
    check_val("t4_moves_no_centre", move_cnt, 15);
    check_val("t4_latency", cyc, exp_err_cyc);
    check_val("t4_busy_at_err", 32'(lane.BUSY), 0);

    // 5: out-of-range at tap 5, pass 3..5 -> sweep stops after tap 5, centre 3+1
    run_train(16'hFFC7, 1'b0, 5);
    check_val("t5_done", done_cnt, 1);
    check_val("t5_center", res_center, 4);
    check_val("t5_winlen", res_win, 3);
    check_val("t5_centre_moves", move_cnt, 4);
    check_val("t5_latency", cyc, 95);
    check_val("t5_rules", viol, 0);

    // 6: reset while sampling tap 6, then a fresh training run
    setup_run(16'h0000, 1'b0, 255);
    lane.START = 1'b1;
    tick();
    while (!(clear_seen && model_tap == 6) && cyc < 2000) tick();
    check_val("t6_reached_tap6", model_tap, 6);
    repeat (3) tick();
    RX_SYNC_RST = 1'b1;
    tick();
    check_idle_outputs("t6_after_rst");
    RX_SYNC_RST = 1'b0;
    tick();
    check_val("t6_tap_left", model_tap, 6);
    run_train(16'hE3E3, 1'b0, 255);
    check_val("t6_done", done_cnt, 1);
    check_val("t6_loads", load_cnt, 2);
    check_val("t6_center", res_center, 3);
    check_val("t6_winlen", res_win, 3);
    check_val("t6_rules", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
